ram_1p_pattern_tester: RTL and testbench
========================================

# ram_1p_pattern_tester

Bus initiator for the single-port synchronous SRAM interface (req/write/addr/wdata in, rvalid/rdata out, one-cycle read latency). On a start command it fills a contiguous, wrapping address window with a seeded incrementing pattern, then reads it back, compares every word and reports pass/fail, an error count and the first failing address. It sits between a control/status source (debug register or boot sequencer) and one instance of the on-chip RAM, and is used for bring-up and memory self-test on the FPGA board.

## Interface
- Width, 32, data word width in bits; must match the attached RAM
- Depth, 128, number of RAM words; must match the attached RAM
- Aw, $clog2(Depth), address width; derived, not overridden
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  start command; sampled only in IDLE
- base_i  in  Aw  first word address, sampled with start
- len_i  in  Aw+1  number of words (0..Depth), sampled with start; values > Depth clamp to Depth
- seed_i  in  Width  pattern seed, sampled with start
- busy_o  out  1  test in progress (WRITE, READ, DRAIN)
- done_o  out  1  single-cycle completion pulse
- pass_o  out  1  1 when last completed test had zero errors
- err_cnt_o  out  Aw+1  mismatching words in last/current test
- first_err_valid_o  out  1  at least one mismatch recorded
- first_err_addr_o  out  Aw  RAM address of first mismatch
- mem_req_o  out  1  RAM request
- mem_write_o  out  1  RAM write enable (valid with req)
- mem_addr_o  out  Aw  RAM address
- mem_wdata_o  out  Width  RAM write data
- mem_rvalid_i  in  1  RAM read/response valid
- mem_rdata_i  in  Width  RAM read data

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: start_i=1 latches base, clamped length L, seed; clears err_cnt_o, first_err_valid_o, first_err_addr_o, pass_o. L=0 -> DONE; else -> WRITE with offset k=0.
- Address for offset k: (base + k) mod Depth (wraps past Depth-1 to 0; for non-power-of-2 Depth use explicit compare-and-subtract).
- Pattern for offset k: (seed + k) mod 2^Width, k zero-extended.
- WRITE: one write per cycle, mem_req_o=1, mem_write_o=1, k=0..L-1; after k=L-1 -> READ with k=0.
- READ: one read per cycle, mem_req_o=1, mem_write_o=0, k=0..L-1; each issued read records its expected offset in a one-deep pending register; after k=L-1 -> DRAIN.
- Compare: on mem_rvalid_i=1 with a pending read, mem_rdata_i != expected -> err_cnt_o+1; if first_err_valid_o=0, set it and capture address of that offset. mem_rvalid_i with no pending read (e.g. write acks) ignored.
- DRAIN: one cycle, mem_req_o=0, final compare; -> DONE.
- DONE: done_o=1, pass_o=(err_cnt_o==0) (err_cnt_o including DRAIN-cycle compare); -> IDLE.
- start_i outside IDLE ignored. err_cnt_o cannot overflow (max Depth fits Aw+1 bits).
- mem_* outputs, busy_o, done_o decoded from registered state/counters only; no combinational path from any input to any output.

## Timing
- Reset: state=IDLE; busy_o, done_o, pass_o, err_cnt_o, first_err_valid_o, first_err_addr_o, mem_req_o, mem_write_o = 0; mem_addr_o, mem_wdata_o = 0.
- Reset mid-operation: next cycle IDLE with all reset values; mem_req_o drops in that cycle; in-flight responses ignored.
- start accepted at edge 0 (L>=1): writes in cycles 1..L, reads in cycles L+1..2L, compares in cycles L+2..2L+1 (DRAIN = 2L+1), done_o in cycle 2L+2, busy_o in cycles 1..2L+1, IDLE again cycle 2L+3 (new start accepted at that edge).
- L=0: done_o in cycle 1, pass_o=1, no mem_req_o.
- Results hold until the next accepted start.

## Test plan
- Clean RAM model, base=0, len=4, seed=0x1000_0000 -> writes 0x1000_0000..0x1000_0003 to addr 0..3, reads back, done_o in cycle 10, pass_o=1, err_cnt_o=0.
- Wrap: base=126, len=4, seed=0 -> addresses 126,127,0,1 in write and read phases; pass_o=1.
- Fault: RAM model with bit 0 stuck-at-0 at addr 5, base=4, len=4, seed=0 -> expected 1 at addr 5 read as 0; err_cnt_o=1, first_err_addr_o=5, first_err_valid_o=1, pass_o=0; two faults (addr 5, 6) -> err_cnt_o=2, first_err_addr_o=5.
- len=0 -> done_o in cycle 1, pass_o=1, mem_req_o never asserted; len=200 -> clamped to 128, done_o in cycle 258.
- start_i pulsed during WRITE with different base -> ignored; original run completes unchanged.
- rst_i asserted during READ -> next cycle all outputs at reset values, mem_req_o=0; a fresh start then completes with pass_o=1.

Source files
------------

// File: rtl/ram_1p_pattern_tester.sv
// Single-port SRAM self-test initiator: writes a seeded incrementing pattern over a
// wrapping address window, reads it back, and reports error count and first failing address.
module ram_1p_pattern_tester #(
    parameter int  Width = 32,
    parameter int  Depth = 128,
    localparam int Aw    = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [Aw-1:0]    base_i,
    input  logic [Aw:0]      len_i,
    input  logic [Width-1:0] seed_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [Aw:0]      err_cnt_o,
    output logic             first_err_valid_o,
    output logic [Aw-1:0]    first_err_addr_o,
    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic [Aw-1:0]    mem_addr_o,
    output logic [Width-1:0] mem_wdata_o,
    input  logic             mem_rvalid_i,
    input  logic [Width-1:0] mem_rdata_i
);

    localparam logic [Aw:0]      DEPTH_LEN = (Aw+1)'(Depth);
    localparam logic [Aw:0]      LEN_ONE   = (Aw+1)'(1);
    localparam logic [Aw-1:0]    LAST_ADDR = Aw'(Depth - 1);
    localparam logic [Aw-1:0]    ADDR_ONE  = Aw'(1);
    localparam logic [Width-1:0] PAT_ONE   = Width'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [Aw:0]      k_q, k_d;
    logic [Aw-1:0]    addr_q, addr_d;
    logic [Width-1:0] pat_q, pat_d;
    logic [Aw-1:0]    base_q, base_d;
    logic [Aw:0]      len_q, len_d;
    logic [Width-1:0] seed_q, seed_d;
    logic             pend_vld_q, pend_vld_d;
    logic [Aw-1:0]    pend_addr_q, pend_addr_d;
    logic [Width-1:0] pend_exp_q, pend_exp_d;
    logic [Aw:0]      err_cnt_q, err_cnt_d;
    logic             first_err_valid_q, first_err_valid_d;
    logic [Aw-1:0]    first_err_addr_q, first_err_addr_d;
    logic             pass_q, pass_d;
    logic [Aw-1:0]    addr_next;
    logic             last_k;

    // Explicit compare-and-wrap keeps non-power-of-2 depths correct.
    assign addr_next = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
    assign last_k    = (k_q == len_q - LEN_ONE);

    always_comb begin
        state_d           = state_q;
        k_d               = k_q;
        addr_d            = addr_q;
        pat_d             = pat_q;
        base_d            = base_q;
        len_d             = len_q;
        seed_d            = seed_q;
        pend_vld_d        = (state_q == READ);
        pend_addr_d       = addr_q;
        pend_exp_d        = pat_q;
        err_cnt_d         = err_cnt_q;
        first_err_valid_d = first_err_valid_q;
        first_err_addr_d  = first_err_addr_q;
        pass_d            = pass_q;

        // Responses without a pending read (write acks, stale data) fall through here.
        if (mem_rvalid_i && pend_vld_q && (mem_rdata_i != pend_exp_q)) begin
            err_cnt_d = err_cnt_q + LEN_ONE;
            if (!first_err_valid_q) begin
                first_err_valid_d = 1'b1;
                first_err_addr_d  = pend_addr_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d            = base_i;
                    seed_d            = seed_i;
                    len_d             = (len_i > DEPTH_LEN) ? DEPTH_LEN : len_i;
                    k_d               = '0;
                    addr_d            = base_i;
                    pat_d             = seed_i;
                    err_cnt_d         = '0;
                    first_err_valid_d = 1'b0;
                    first_err_addr_d  = '0;
                    pass_d            = (len_i == '0);
                    state_d           = (len_i == '0) ? DONE : WRITE;
                end
            end
            WRITE, READ: begin
                if (last_k) begin
                    k_d     = '0;
                    addr_d  = base_q;
                    pat_d   = seed_q;
                    state_d = (state_q == WRITE) ? READ : DRAIN;
                end else begin
                    k_d    = k_q + LEN_ONE;
                    addr_d = addr_next;
                    pat_d  = pat_q + PAT_ONE;
                end
            end
            DRAIN: begin
                pass_d  = (err_cnt_d == '0);
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= IDLE;
            k_q               <= '0;
            addr_q            <= '0;
            pat_q             <= '0;
            pend_vld_q        <= 1'b0;
            err_cnt_q         <= '0;
            first_err_valid_q <= 1'b0;
            first_err_addr_q  <= '0;
            pass_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            k_q               <= k_d;
            addr_q            <= addr_d;
            pat_q             <= pat_d;
            pend_vld_q        <= pend_vld_d;
            err_cnt_q         <= err_cnt_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_addr_q  <= first_err_addr_d;
            pass_q            <= pass_d;
        end
    end

    // Run parameters and pending-read data only matter while their valid/state is set.
    always_ff @(posedge clk_i) begin
        base_q      <= base_d;
        len_q       <= len_d;
        seed_q      <= seed_d;
        pend_addr_q <= pend_addr_d;
        pend_exp_q  <= pend_exp_d;
    end

    assign busy_o            = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
    assign done_o            = (state_q == DONE);
    assign pass_o            = pass_q;
    assign err_cnt_o         = err_cnt_q;
    assign first_err_valid_o = first_err_valid_q;
    assign first_err_addr_o  = first_err_addr_q;
    assign mem_req_o         = (state_q == WRITE) || (state_q == READ);
    assign mem_write_o       = (state_q == WRITE);
    assign mem_addr_o        = addr_q;
    assign mem_wdata_o       = pat_q;

endmodule

// File: tb/tb_ram_1p_pattern_tester.sv
// Bench for ram_1p_pattern_tester: RAM model with stuck-at fault masks and a
// per-run reference model of bus trace and results.
module tb_ram_1p_pattern_tester;
    localparam int W  = 32;
    localparam int D  = 128;
    localparam int AW = 7;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] base_i;
    logic [AW:0]   len_i;
    logic [W-1:0]  seed_i;
    logic          busy_o, done_o, pass_o;
    logic [AW:0]   err_cnt_o;
    logic          first_err_valid_o;
    logic [AW-1:0] first_err_addr_o;
    logic          mem_req_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [W-1:0]  mem_wdata_o;
    logic          mem_rvalid_i;
    logic [W-1:0]  mem_rdata_i;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] mem [D];
    logic [W-1:0] s0  [D];
    logic [W-1:0] s1  [D];

    ram_1p_pattern_tester #(.Width(W), .Depth(D)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_i(base_i),
        .len_i(len_i), .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .err_cnt_o(err_cnt_o), .first_err_valid_o(first_err_valid_o),
        .first_err_addr_o(first_err_addr_o), .mem_req_o(mem_req_o),
        .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // RAM model: one-cycle latency, acks writes too, stuck bits applied on read.
    always @(posedge clk_i) begin
        mem_rvalid_i <= mem_req_o;
        if (mem_req_o) begin
            if (mem_write_o) begin
                mem[mem_addr_o] <= mem_wdata_o;
                mem_rdata_i     <= 32'hDEAD_BEEF;
            end else begin
                mem_rdata_i <= (mem[mem_addr_o] & ~s0[mem_addr_o]) | s1[mem_addr_o];
            end
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < D; i++) begin
            s0[i] = '0;
            s1[i] = '0;
        end
    endtask

    task automatic test_reset();
        logic [63:0] got;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        got = {busy_o, done_o, pass_o, err_cnt_o, first_err_valid_o, first_err_addr_o,
               mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o};
        vectors++;
        if (got !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_state: outputs=%h required 0", got);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    // Full run with trace check every cycle; pulse_cyc>0 injects a start during the run.
    task automatic run_test(input int base, input int len, input logic [W-1:0] seed,
                            input int pulse_cyc, input string name);
        int L, total, err, fa, k;
        logic fv;
        logic [3:0] exp_ctl, got_ctl;
        logic [W-1:0] e, rd;
        logic ok;
        L   = (len > D) ? D : len;
        err = 0; fv = 1'b0; fa = 0;
        for (int j = 0; j < L; j++) begin
            e  = seed + W'(j);
            rd = (e & ~s0[(base + j) % D]) | s1[(base + j) % D];
            if (rd != e) begin
                err++;
                if (!fv) begin
                    fv = 1'b1;
                    fa = (base + j) % D;
                end
            end
        end
        total = (L == 0) ? 1 : 2 * L + 2;

        @(negedge clk_i);
        start_i = 1'b1;
        base_i  = AW'(base);
        len_i   = (AW+1)'(len);
        seed_i  = seed;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 1; c <= total; c++) begin
            exp_ctl = {(L > 0 && c <= 2 * L + 1), (c == total), (L > 0 && c <= 2 * L), (L > 0 && c <= L)};
            got_ctl = {busy_o, done_o, mem_req_o, mem_write_o};
            k = (c <= L) ? c - 1 : c - L - 1;
            ok = (got_ctl === exp_ctl);
            if (exp_ctl[1] && mem_addr_o !== AW'((base + k) % D)) ok = 1'b0;
            if (exp_ctl[0] && mem_wdata_o !== seed + W'(k)) ok = 1'b0;
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL %s trace c=%0d: busy/done/req/we=%b addr=%0d wdata=%h required %b addr=%0d wdata=%h",
                         name, c, got_ctl, mem_addr_o, mem_wdata_o, exp_ctl, (base + k) % D, seed + W'(k));
            end
            if (c == total) begin
                vectors++;
                if ({pass_o, err_cnt_o, first_err_valid_o, first_err_addr_o} !==
                    {(err == 0), (AW+1)'(err), fv, AW'(fa)}) begin
                    miscompares++;
                    $display("FAIL %s result: pass=%0b err=%0d fv=%0b fa=%0d required pass=%0b err=%0d fv=%0b fa=%0d",
                             name, pass_o, err_cnt_o, first_err_valid_o, first_err_addr_o, (err == 0), err, fv, fa);
                end
            end
            start_i = (c == pulse_cyc);
            if (c == pulse_cyc) base_i = AW'(base + 37);
            @(negedge clk_i);
            start_i = 1'b0;
        end
        vectors++;
        if ({busy_o, done_o, pass_o, err_cnt_o, first_err_valid_o, first_err_addr_o} !==
            {2'b00, (err == 0), (AW+1)'(err), fv, AW'(fa)}) begin
            miscompares++;
            $display("FAIL %s hold: busy=%0b done=%0b pass=%0b err=%0d fv=%0b fa=%0d required 0 0 %0b %0d %0b %0d",
                     name, busy_o, done_o, pass_o, err_cnt_o, first_err_valid_o, first_err_addr_o,
                     (err == 0), err, fv, fa);
        end
    endtask

    task automatic test_basic();
        clear_faults();
        run_test(0, 4, 32'h1000_0000, 0, "basic");
    endtask

    task automatic test_wrap();
        clear_faults();
        run_test(126, 4, 32'h0, 0, "wrap");
    endtask

    task automatic test_faults();
        clear_faults();
        s0[5] = 32'h1;
        run_test(4, 4, 32'h0, 0, "fault1");
        s0[6] = 32'h2;
        run_test(4, 4, 32'h0, 0, "fault2");
        clear_faults();
        s1[20] = 32'h8000_0000;
        run_test(10, 30, 32'h1234_5678, 0, "fault_s1");
    endtask

    task automatic test_len_edges();
        logic seen_req;
        clear_faults();
        seen_req = 1'b0;
        fork
            begin
                run_test(50, 0, 32'hABCD_0000, 0, "len0");
            end
            begin
                repeat (4) begin
                    @(negedge clk_i);
                    if (mem_req_o) seen_req = 1'b1;
                end
            end
        join
        vectors++;
        if (seen_req !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_noreq: mem_req seen=%0b required 0", seen_req);
        end
        run_test(3, 200, 32'hFFFF_FFF0, 0, "len200");
    endtask

    task automatic test_start_ignored();
        clear_faults();
        run_test(20, 6, 32'h5555_0000, 2, "start_ignored");
    endtask

    task automatic test_reset_mid();
        logic [63:0] got;
        clear_faults();
        @(negedge clk_i);
        start_i = 1'b1; base_i = 7'd10; len_i = 8'd8; seed_i = 32'h0000_0100;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        got = {busy_o, done_o, pass_o, err_cnt_o, first_err_valid_o, first_err_addr_o,
               mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o};
        vectors++;
        if (got !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_mid: outputs=%h required 0", got);
        end
        rst_i = 1'b0;
        run_test(60, 5, 32'h7777_0000, 0, "after_reset");
    endtask

    task automatic test_random();
        int na;
        for (int r = 0; r < 10; r++) begin
            clear_faults();
            na = $urandom_range(0, 3);
            for (int f = 0; f < na; f++) begin
                s0[$urandom_range(0, D - 1)] = $urandom;
                if ($urandom_range(0, 1) == 1) s1[$urandom_range(0, D - 1)] = 32'h1 << $urandom_range(0, 31);
            end
            run_test($urandom_range(0, D - 1), $urandom_range(0, 200), $urandom, 0, "random");
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; base_i = '0; len_i = '0; seed_i = '0;
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        for (int i = 0; i < D; i++) mem[i] = '0;
        clear_faults();
        test_reset();
        test_basic();
        test_wrap();
        test_faults();
        test_len_edges();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
